// File: rtl/pellet_tracker_if.sv
// ============================================================================
// Module  : pellet_tracker_if
// Purpose : Raster pixel, game control and status bundle of the pellet tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pellet_tracker_if;
  logic        start;
  logic        ack;
  logic        lose;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        pacmanFill;
  logic        pelletFill;
  logic [15:0] score;
  logic        win;
  logic        qIni;
  logic        qPlay;
  logic        qWin;
  logic        qLose;

  modport master (
    output start, ack, lose, hCount, vCount, pacmanFill,
    input  pelletFill, score, win, qIni, qPlay, qWin, qLose
  );

  modport slave (
    input  start, ack, lose, hCount, vCount, pacmanFill,
    output pelletFill, score, win, qIni, qPlay, qWin, qLose
  );
endinterface

`default_nettype wire

// File: rtl/pellet_tracker.sv
// ============================================================================
// Module  : pellet_tracker
// Purpose : Pellet grid, eat detection, score keeping and win/lose game FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pellet_tracker #(
  parameter int OFFSETH   = 274,
  parameter int OFFSETV   = 58,
  parameter int X0        = 20,
  parameter int Y0        = 20,
  parameter int PITCH_X   = 68,
  parameter int PITCH_Y   = 96,
  parameter int COLS      = 6,
  parameter int ROWS      = 5,
  parameter int PEL_SIZE  = 5,
  parameter int WIN_SCORE = 30
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pellet_tracker_if.slave bus
);

  localparam int c_hw   = (PEL_SIZE - 1) / 2;
  localparam int c_npel = COLS * ROWS;

  localparam logic [3:0] c_st_ini  = 4'b0001;
  localparam logic [3:0] c_st_play = 4'b0010;
  localparam logic [3:0] c_st_win  = 4'b0100;
  localparam logic [3:0] c_st_lose = 4'b1000;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [c_npel-1:0] r_alive;
  logic [c_npel-1:0] w_inside;
  logic [c_npel-1:0] w_match;
  logic [15:0]       r_score;
  logic              w_hit;
  logic              w_final;
  logic              w_reload;

  // Every pellet owns a fixed screen window; the pitches keep windows disjoint.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam logic [9:0] c_hlo = 10'(OFFSETH + X0 + c * PITCH_X - c_hw);
      localparam logic [9:0] c_hhi = 10'(OFFSETH + X0 + c * PITCH_X + c_hw);
      localparam logic [9:0] c_vlo = 10'(OFFSETV + Y0 + r * PITCH_Y - c_hw);
      localparam logic [9:0] c_vhi = 10'(OFFSETV + Y0 + r * PITCH_Y + c_hw);
      assign w_inside[r*COLS+c] = (bus.hCount >= c_hlo) && (bus.hCount <= c_hhi) &&
                                  (bus.vCount >= c_vlo) && (bus.vCount <= c_vhi);
    end
  end

  assign w_match        = w_inside & r_alive;
  assign bus.pelletFill = |w_match;
  assign w_hit          = bus.pelletFill & bus.pacmanFill & (r_state == c_st_play);
  assign w_final        = w_hit && (r_score == 16'(WIN_SCORE - 1));
  assign w_reload       = (r_state == c_st_ini) ||
                          (((r_state == c_st_win) || (r_state == c_st_lose)) && bus.ack);
  assign bus.score      = r_score;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_ini;
    else       r_state <= w_next;
  end

  // A final eat outranks a simultaneous lose.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_ini:  if (bus.start) w_next = c_st_play;
      c_st_play: begin
        if (w_final)       w_next = c_st_win;
        else if (bus.lose) w_next = c_st_lose;
      end
      c_st_win:  if (bus.ack) w_next = c_st_ini;
      c_st_lose: if (bus.ack) w_next = c_st_ini;
      default:   w_next = c_st_ini;
    endcase
  end

  always_comb begin
    bus.qIni  = (r_state == c_st_ini);
    bus.qPlay = (r_state == c_st_play);
    bus.qWin  = (r_state == c_st_win);
    bus.qLose = (r_state == c_st_lose);
    bus.win   = (r_state == c_st_win);
  end

  // The eaten pellet stops matching next cycle, so each pellet scores once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alive <= '1;
      r_score <= '0;
    end else if (w_reload) begin
      r_alive <= '1;
      r_score <= '0;
    end else if (w_hit) begin
      r_alive <= r_alive & ~w_match;
      r_score <= r_score + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: doc/pellet_tracker.md
Name: pellet_tracker

Overview:
- Downstream consumer of the pacman movement stage. Tracks a 6x5 grid of pellets in the play area and detects pacman eating them, pixel by pixel, during the VGA raster.
- Maintains the score and drives the pellet colour signal for the VGA mux.
- Raises win when all pellets are eaten; its score output feeds the movement stage's score input.

Parameters:
- OFFSETH, 274, screen-to-play-area horizontal offset (130 custom + 144 blanking)
- OFFSETV, 58, screen-to-play-area vertical offset (24 custom + 34 blanking)
- X0, 20, play-area x of column-0 pellet centre
- Y0, 20, play-area y of row-0 pellet centre
- PITCH_X, 68, column spacing in pixels
- PITCH_Y, 96, row spacing in pixels
- COLS, 6, pellet columns
- ROWS, 5, pellet rows
- PEL_SIZE, 5, pellet side length in pixels (odd, centred; half-width HW=(PEL_SIZE-1)/2)
- WIN_SCORE, 30, score that ends the game as a win (= COLS*ROWS)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  leave INI and begin play
- ack  in  1  acknowledge end of game, return to INI
- lose  in  1  game lost (ghost collision), sampled in PLAY
- hCount  in  10  current raster column (screen coordinates)
- vCount  in  10  current raster row (screen coordinates)
- pacmanFill  in  1  current pixel is covered by pacman
- pelletFill  out  1  current pixel lies on a live pellet
- score  out  16  pellets eaten this game
- win  out  1  high while in WIN state
- qIni, qPlay, qWin, qLose  out  1 each  one-hot state outputs

Behaviour:
- Pellet k=r*COLS+c, with 0<=k<COLS*ROWS.
  - Centre on screen: h=OFFSETH+X0+c*PITCH_X, v=OFFSETV+Y0+r*PITCH_Y.
  - Pellet covers h-HW..h+HW and v-HW..v+HW, inclusive.
- alive: one register bit per pellet.
- Pixel-to-pellet match: parallel compare against all pellets. Because the pitches exceed PEL_SIZE, at most one pellet matches any pixel.
- pelletFill: combinational, zero latency. Equals "pixel inside pellet k AND alive[k]", in every state.
- hit = pelletFill AND pacmanFill AND qPlay.
- On the posedge where hit=1:
  - alive[k] <= 0;
  - score <= score+1.
  - From the next cycle the pixel no longer matches, so one pellet is counted exactly once even though many pacman pixels overlap it, and regardless of pixel-clock divide ratio.
- State machine (one-hot, registered):
  - INI: alive = all ones, score = 0. start -> PLAY.
  - PLAY:
    - If hit and score+1 == WIN_SCORE -> WIN; the score update still occurs that cycle.
    - Else if lose -> LOSE.
    - A simultaneous final eat and lose goes to WIN.
  - WIN: win=1. score and alive frozen. ack -> INI.
  - LOSE: score and alive frozen. ack -> INI.
  - Entering INI via ack reloads alive to all ones and score to 0 on the same edge.
- Reset (async) forces:
  - state INI (qIni=1, other q outputs 0);
  - alive all ones;
  - score=0;
  - win=0.
  - Reset mid-PLAY discards progress immediately; pelletFill reflects all-alive within the same cycle reset is asserted.
- start outside INI, and ack outside WIN/LOSE, are ignored. lose outside PLAY is ignored.
- score is 16 bits and never exceeds WIN_SCORE (no increment outside PLAY).
- Offscreen or blanking hCount/vCount values match no pellet: pelletFill=0, no hit.

Test Plan:
- Reset, then sweep a full frame with pacmanFill=0 -> pelletFill high on exactly 30*25=750 pixels; pixel (h=294,v=78) lit; (h=297,v=78) dark; qIni=1, score=0.
- start, drive hCount=294/vCount=78 with pacmanFill=1 for 10 consecutive cycles -> score=1 after the first edge only, alive[0]=0, pelletFill=0 at (294,78) thereafter.
- In INI, drive pacmanFill=1 over pellet 5 at (h=634,v=78) -> no score change; pelletFill stays 1.
- In PLAY, eat all 30 pellets (last at h=634,v=462) -> score=30, qWin=1 and win=1 on the edge of the 30th hit. Further pacman overlaps give no change. ack -> qIni=1, score=0, all 750 pixels lit again.
- In PLAY with score=29, assert lose in the same cycle as the final hit -> WIN, score=30. Separate run with score=12, assert lose -> qLose=1, score holds at 12 through 100 cycles of overlap stimulus.
- Assert reset asynchronously mid-PLAY at score=7 -> score=0, qIni=1, pelletFill for pellet 0 restored before the next clk edge.
